// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  // Default operand/result width.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic             bin;
  logic [WIDTH-1:0] y;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  // Requester side: issues operands, observes results.
  modport master (
    output start, x1, x2, bin,
    input  y, bout, ovf, busy, done
  );

  // Subtractor side.
  modport slave (
    input  start, x1, x2, bin,
    output y, bout, ovf, busy, done
  );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_adder_1b.sv
// One-bit full-adder cell, the same cell the ripple-carry adder is built from.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of three input bits.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule : full_adder_1b

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: y = x1 - x2 - bin, LSB first,
// computed as x1 + ~x2 + ~bin through a single full-adder cell.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // a_q shifts x1 right; the freed MSB positions collect the difference bits,
  // so the same register doubles as the result shift register.
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sum_s;
  logic               cout_s;
  logic               last_s;

  full_adder_1b u_fa (
    .a    (a_q[0]),
    .b    (~b_q[0]),
    .cin  (carry_q),
    .s    (sum_s),
    .cout (cout_s)
  );

  assign last_s = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    y_d     = y_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = {CNT_W{1'b0}};
          a_d     = bus.x1;
          b_d     = bus.x2;
          carry_d = ~bus.bin;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = {sum_s, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = cout_s;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_s) begin
          // Final bit: a_q[0]/b_q[0] hold the operand MSBs, sum_s is y's MSB.
          state_d = DONE;
          cnt_d   = {CNT_W{1'b0}};
          y_d     = {sum_s, a_q[WIDTH-1:1]};
          bout_d  = ~cout_s;
          ovf_d   = (a_q[0] != b_q[0]) && (sum_s != a_q[0]);
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      y_q     <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      y_q     <= y_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x1;
    logic [7:0] x2;
    logic       bin;
    logic [7:0] y;
    logic       bout;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       output logic [7:0] y, output logic bo, output logic ov);
    int u;
    int s;
    u  = int'(a) - int'(b) - int'(bi);
    s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
    bo = (u < 0);
    y  = 8'(u + 256);
    ov = (s < -128) || (s > 127);
  endtask

  // Issue one operation from idle and wait for its done pulse.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input bit scramble,
                        output logic [7:0] y, output logic bo, output logic ov);
    int  lat;
    int  busy_cnt;
    bit  got;
    @(negedge clk);
    bus.start = 1'b1; bus.x1 = a; bus.x2 = b; bus.bin = bi;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (scramble) begin
      bus.x1 = 8'($urandom); bus.x2 = 8'($urandom); bus.bin = 1'($urandom);
    end
    lat = 0; busy_cnt = 0; got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (scramble && i == 3) begin
        bus.start = 1'b1; bus.x1 = 8'($urandom);
      end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1; lat = i;
      end else if (bus.busy) begin
        busy_cnt++;
      end
    end
    chk("latency", lat, 9);
    chk("busy_cycles", busy_cnt, 8);
    y = bus.y; bo = bus.bout; ov = bus.ovf;
  endtask

  initial begin
    vec_t        tbl[8];
    vec_t        seq[4];
    logic [7:0]  ry, my;
    logic        rb, ro, mb, mo;
    int          lat;
    bit          seen;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.x1 = 8'd0; bus.x2 = 8'd0; bus.bin = 1'b0;

    tbl[0] = '{8'd200, 8'd55,  1'b0, 8'd145,  1'b0, 1'b0};
    tbl[1] = '{8'd5,   8'd10,  1'b0, 8'd251,  1'b1, 1'b0};
    tbl[2] = '{8'd0,   8'd0,   1'b1, 8'd255,  1'b1, 1'b0};
    tbl[3] = '{8'h80,  8'h01,  1'b0, 8'h7F,   1'b0, 1'b1};
    tbl[4] = '{8'h7F,  8'hFF,  1'b0, 8'h80,   1'b1, 1'b1};
    tbl[5] = '{8'd0,   8'd1,   1'b0, 8'hFF,   1'b1, 1'b0};
    tbl[6] = '{8'hFF,  8'hFF,  1'b1, 8'hFF,   1'b1, 1'b0};
    tbl[7] = '{8'h80,  8'h00,  1'b1, 8'h7F,   1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y", bus.y, 0); chk("rst_bout", bus.bout, 0); chk("rst_ovf", bus.ovf, 0);
    chk("rst_busy", bus.busy, 0); chk("rst_done", bus.done, 0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].x1, tbl[i].x2, tbl[i].bin, (i % 2) == 1, ry, rb, ro);
      chk($sformatf("tbl%0d_y", i), ry, tbl[i].y);
      chk($sformatf("tbl%0d_bout", i), rb, tbl[i].bout);
      chk($sformatf("tbl%0d_ovf", i), ro, tbl[i].ovf);
    end

    // Outputs hold across IDLE
    repeat (5) @(negedge clk);
    chk("hold_y", bus.y, tbl[7].y);
    chk("hold_ovf", bus.ovf, tbl[7].ovf);

    // Back-to-back: start held high, new operands after each accept
    seq[0] = '{8'd10, 8'd3,   1'b0, 8'd7,   1'b0, 1'b0};
    seq[1] = '{8'd3,  8'd10,  1'b1, 8'hF8,  1'b1, 1'b0};
    seq[2] = '{8'h90, 8'h20,  1'b0, 8'h70,  1'b0, 1'b1};
    seq[3] = '{8'd77, 8'd77,  1'b0, 8'd0,   1'b0, 1'b0};
    @(negedge clk);
    bus.start = 1'b1; bus.x1 = seq[0].x1; bus.x2 = seq[0].x2; bus.bin = seq[0].bin;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      if (k + 1 < 4) begin
        bus.x1 = seq[k+1].x1; bus.x2 = seq[k+1].x2; bus.bin = seq[k+1].bin;
      end else begin
        bus.start = 1'b0;
      end
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
        @(negedge clk);
        if (bus.done) lat = i;
      end
      chk($sformatf("b2b%0d_interval", k), lat, 9);
      chk($sformatf("b2b%0d_y", k), bus.y, seq[k].y);
      chk($sformatf("b2b%0d_bout", k), bus.bout, seq[k].bout);
      chk($sformatf("b2b%0d_ovf", k), bus.ovf, seq[k].ovf);
      @(posedge clk); #1;
    end

    // Reset mid-operation
    run_op(8'd200, 8'd55, 1'b0, 1'b0, ry, rb, ro);
    @(negedge clk);
    bus.start = 1'b1; bus.x1 = 8'd100; bus.x2 = 8'd1; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_y", bus.y, 0); chk("midrst_bout", bus.bout, 0);
    chk("midrst_busy", bus.busy, 0); chk("midrst_done", bus.done, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run_op(8'd9, 8'd3, 1'b0, 1'b0, ry, rb, ro);
    chk("post_rst_y", ry, 8'd6);
    chk("post_rst_bout", rb, 0);

    // Randomized against the reference model
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] a, b;
      logic       bi;
      a  = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
      if (n < 4) begin
        a = (n[0]) ? 8'hFF : 8'h00; b = (n[1]) ? 8'hFF : 8'h00;
      end
      model(a, b, bi, my, mb, mo);
      run_op(a, b, bi, (n % 3) == 0, ry, rb, ro);
      chk($sformatf("rnd%0d_y", n), ry, my);
      chk($sformatf("rnd%0d_bout", n), rb, mb);
      chk($sformatf("rnd%0d_ovf", n), ro, mo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_serial_subtractor
